sort4_seq: RTL

SORT4_SEQ -- requirements
Module: sort4_seq

---
 rtl/sort4_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sort4_seq.sv
// Four-element sequential sorter: load 4 nibbles, run a 9-cycle bubble sort with a
// single shared comparator, then stream the sorted elements out with valid/ready.
module sort4_seq #(
  parameter bit DESC = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [3:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic [2:0] swap_cnt
);

  typedef enum logic [1:0] {StLoad, StSort, StOut} state_e;

  state_e      state_q, state_d;
  logic [3:0]  buf_q [4];
  logic [3:0]  buf_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [3:0]  step_q, step_d;
  logic [2:0]  swap_cnt_q, swap_cnt_d;

  logic [1:0]  pair_lo;
  logic [1:0]  pair_hi;
  logic [3:0]  op_lo;
  logic [3:0]  op_hi;
  logic [3:0]  cmp_lhs;
  logic [3:0]  cmp_rhs;
  logic        do_swap;

  // Pair index is step mod 3; steps 9..15 never occur while sorting.
  always_comb begin
    case (step_q)
      4'd0, 4'd3, 4'd6: pair_lo = 2'd0;
      4'd1, 4'd4, 4'd7: pair_lo = 2'd1;
      default:          pair_lo = 2'd2;
    endcase
    pair_hi = pair_lo + 2'd1;
  end

  assign op_lo = buf_q[pair_lo];
  assign op_hi = buf_q[pair_hi];

  // One strict greater-than serves both orders; operands swap for descending.
  assign cmp_lhs = DESC ? op_hi : op_lo;
  assign cmp_rhs = DESC ? op_lo : op_hi;
  assign do_swap = cmp_lhs > cmp_rhs;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    step_d     = step_q;
    swap_cnt_d = swap_cnt_q;

    case (state_q)
      StLoad: begin
        if (in_valid) begin
          buf_d[wr_ptr_q] = in_data;
          wr_ptr_d        = wr_ptr_q + 2'd1;
          if (wr_ptr_q == 2'd3) begin
            state_d    = StSort;
            step_d     = 4'd0;
            swap_cnt_d = 3'd0;
          end
        end
      end
      StSort: begin
        if (do_swap) begin
          buf_d[pair_lo] = op_hi;
          buf_d[pair_hi] = op_lo;
          swap_cnt_d     = swap_cnt_q + 3'd1;
        end
        if (step_q == 4'd8) begin
          state_d  = StOut;
          rd_ptr_d = 2'd0;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      StOut: begin
        if (out_ready) begin
          rd_ptr_d = rd_ptr_q + 2'd1;
          if (rd_ptr_q == 2'd3) begin
            state_d = StLoad;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StLoad;
      buf_q[0]   <= 4'd0;
      buf_q[1]   <= 4'd0;
      buf_q[2]   <= 4'd0;
      buf_q[3]   <= 4'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      step_q     <= 4'd0;
      swap_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      step_q     <= step_d;
      swap_cnt_q <= swap_cnt_d;
    end
  end

  assign in_ready  = (state_q == StLoad);
  assign out_valid = (state_q == StOut);
  assign busy      = (state_q != StLoad);
  assign out_data  = buf_q[rd_ptr_q];
  assign swap_cnt  = swap_cnt_q;

endmodule
